extra2lp_top: RTL and testbench



---
 rtl/extra2lp_pkg.sv | 15 +
 rtl/extra2lp_if.sv | 14 +
 rtl/extra2lp_mul_pipe.sv | 35 +++
 rtl/extra2lp_top.sv | 45 ++++
 tb/tb_extra2lp_top.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/extra2lp_pkg.sv
// Shared widths and types for the extra2lp multiply-accumulate pipeline.
// Saturation of the result is enabled by defining EXTRA2LP_SATURATE_EN.
package extra2lp_pkg;

  localparam int IN_W   = 32;
  localparam int OUT_W  = 36;
  localparam int PROD_W = 64;

  typedef logic [IN_W-1:0]   operand_t;
  typedef logic [PROD_W-1:0] product_t;
  typedef logic [OUT_W-1:0]  result_t;

  localparam result_t OUT_MAX = {OUT_W{1'b1}};

endpackage

// File: rtl/extra2lp_if.sv
// Operand/result bundle for extra2lp_top. Free-running datapath: there is no
// valid/ready pair; a new operand triple is taken on every rising clock edge.
interface extra2lp_if;
  import extra2lp_pkg::*;

  operand_t A_in;
  operand_t B_in;
  operand_t C_in;
  result_t  Q;

  modport master (output A_in, output B_in, output C_in, input Q);
  modport slave  (input A_in, input B_in, input C_in, output Q);

endinterface

// File: rtl/extra2lp_mul_pipe.sv
// Stages 1-2: input capture registers, then a registered 32x32 unsigned
// product with the addend delayed alongside it.
module extra2lp_mul_pipe
  import extra2lp_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  operand_t a,
  input  operand_t b,
  input  operand_t c,
  output product_t p,
  output operand_t c_d
);

  operand_t a_r;
  operand_t b_r;
  operand_t c_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      p   <= '0;
      c_d <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
      c_r <= c;
      p   <= PROD_W'(a_r) * PROD_W'(b_r);
      c_d <= c_r;
    end
  end

endmodule

// File: rtl/extra2lp_top.sv
// Pipelined unsigned multiply-accumulate Q = A*B + C, two-edge latency.
// Define EXTRA2LP_SATURATE_EN to clamp at OUT_MAX instead of wrapping mod 2^36.
module extra2lp_top
  import extra2lp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  extra2lp_if.slave  bus
);

  product_t p;
  operand_t c_d;
  result_t  q_next;

  extra2lp_mul_pipe u_mul_pipe (
    .clk (clk),
    .rst (rst),
    .a   (bus.A_in),
    .b   (bus.B_in),
    .c   (bus.C_in),
    .p   (p),
    .c_d (c_d)
  );

`ifdef EXTRA2LP_SATURATE_EN
  logic [PROD_W:0] sum;

  always_comb begin
    sum = {1'b0, p} + {{(PROD_W+1-IN_W){1'b0}}, c_d};
    // Any set bit above the result width means the true sum exceeds OUT_MAX.
    if (|sum[PROD_W:OUT_W]) q_next = OUT_MAX;
    else                    q_next = sum[OUT_W-1:0];
  end
`else
  always_comb begin
    q_next = OUT_W'({1'b0, p} + {{(PROD_W+1-IN_W){1'b0}}, c_d});
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) bus.Q <= '0;
    else     bus.Q <= q_next;
  end

endmodule

// File: tb/tb_extra2lp_top.sv
// Scoreboard bench for extra2lp_top: directed plan cases, then random stream
// with occasional resets, checked against an arithmetic reference.
module tb_extra2lp_top;
  import extra2lp_pkg::*;

  // clock/reset block
  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  extra2lp_if bus ();

  extra2lp_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  int unsigned      due_q[$];
  bit               h_rst[$];
  operand_t         h_a[$];
  operand_t         h_b[$];
  operand_t         h_c[$];
  int unsigned      n_drv = 0;
  int unsigned      edge_idx = 0;
  int               n_pass = 0;
  int               n_total = 0;

  // Reference: exact arithmetic, then wrap or clamp to the result width.
  function automatic result_t ref_q(operand_t a, operand_t b, operand_t c);
    logic [64:0] full;
    full = 65'(a) * 65'(b) + 65'(c);
`ifdef EXTRA2LP_SATURATE_EN
    if (full > 65'(OUT_MAX)) return OUT_MAX;
`endif
    return full[OUT_W-1:0];
  endfunction

  // Drives one cycle; the value seen after this edge is zero if a reset hit
  // this edge or either of the two before it, else the triple from two edges ago.
  task automatic drive(input bit r, input operand_t a, input operand_t b, input operand_t c);
    result_t e;
    @(negedge clk);
    rst = r;
    bus.A_in = a;
    bus.B_in = b;
    bus.C_in = c;
    h_rst.push_back(r);
    h_a.push_back(a);
    h_b.push_back(b);
    h_c.push_back(c);
    if (n_drv < 2 || r || h_rst[n_drv-1] || h_rst[n_drv-2])
      e = '0;
    else
      e = ref_q(h_a[n_drv-2], h_b[n_drv-2], h_c[n_drv-2]);
    exp_q.push_back(e);
    due_q.push_back(n_drv);
    n_drv++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, '0, '0, '0);
  endtask

  // monitor
  initial begin
    result_t e;
    forever begin
      @(posedge clk);
      #1;
      if (due_q.size() > 0 && due_q[0] == edge_idx) begin
        void'(due_q.pop_front());
        e = exp_q.pop_front();
        n_total++;
        if (bus.Q === e) n_pass++;
        else $display("FAIL q_edge%0d: got %h expected %h", edge_idx, bus.Q, e);
      end
      edge_idx++;
    end
  end

  // stimulus
  initial begin
    operand_t ra, rb, rc;
    rst = 1'b1;
    bus.A_in = '0;
    bus.B_in = '0;
    bus.C_in = '0;

    for (int i = 0; i < 3; i++) drive(1'b1, '0, '0, '0);
    idle(3);

    drive(1'b0, 32'd2, 32'd3, 32'd4);
    drive(1'b0, 32'd1, 32'd1, 32'd1);
    drive(1'b0, 32'd2, 32'd2, 32'd3);
    idle(3);

    drive(1'b0, 32'd5, 32'd7, 32'd1);
    idle(3);

    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    drive(1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);

    for (int i = 0; i < 4; i++) drive(1'b0, 32'd100, 32'd200, 32'd300);
    idle(2);

    drive(1'b0, 32'd3, 32'd3, 32'd0);
    drive(1'b0, 32'd4, 32'd4, 32'd0);
    drive(1'b1, 32'd0, 32'd0, 32'd0);
    idle(4);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; rc = $urandom; end
        1: begin ra = 32'hFFFF_FFFF; rb = $urandom; rc = $urandom; end
        2: begin ra = $urandom_range(0, 1); rb = $urandom; rc = $urandom; end
        default: begin
          ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); rc = $urandom_range(0, 255);
        end
      endcase
      drive($urandom_range(0, 19) == 0, ra, rb, rc);
    end
    idle(3);

    for (int i = 0; i < 10 && due_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (due_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d results outstanding, expected 0", due_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
